pad_scheduler: RTL and testbench

Sequences one zero-padded frame from the demosaic output FIFO into the 2-D filter pipeline. It scans a padded grid of (WIDTH+KERNEL-1) x (HEIGHT+KERNEL-1) positions in row-major order. Border positions produce zero pixels without touching the FIFO, and interior positions pop one demosaiced RGB pixel each. After the last position it holds a flush-enable window so the filter can drain, then pulses done. It sits between the boundary FIFO and the filter, in `processing`.

---
 rtl/pad_scheduler.sv | 159 +++++++++++++++
 tb/tb_pad_scheduler.sv | 380 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pad_scheduler.sv
// rtl/pad_scheduler.sv - zero-padded frame sequencer from demosaic FIFO into the 2-D filter
//
// Scans a (WIDTH+KERNEL-1) x (HEIGHT+KERNEL-1) padded grid in row-major order.
// Border slots emit zero pixels without touching the FIFO; interior slots pop one
// pixel each. After the last slot the filter gets FLUSH drain cycles, then oDone pulses.
//
// Ports:
//   clk, reset     clock, synchronous active-high reset
//   iStart         frame start pulse (ignored unless idle)
//   iFifoEmpty     boundary FIFO empty flag
//   iFifoQ         FIFO read data, valid the cycle after oFifoRdreq
//   oFifoRdreq     FIFO pop, combinational from state, scan position and iFifoEmpty
//   oData/oValid   pixel to filter (zero for pad slots and whenever oValid is low)
//   oX/oY          padded coordinates of oData
//   oFlush         filter enable while draining
//   oBusy          scheduler not idle
//   oDone          one-cycle end-of-frame pulse
module pad_scheduler #(
    parameter int WIDTH  = 320,
    parameter int HEIGHT = 240,
    parameter int KERNEL = 7,
    parameter int FLUSH  = 2 * (WIDTH + KERNEL - 1),
    parameter int DW     = 24
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          iStart,
    input  logic          iFifoEmpty,
    input  logic [DW-1:0] iFifoQ,
    output logic          oFifoRdreq,
    output logic [DW-1:0] oData,
    output logic          oValid,
    output logic [15:0]   oX,
    output logic [15:0]   oY,
    output logic          oFlush,
    output logic          oBusy,
    output logic          oDone
);

    localparam int B  = (KERNEL - 1) / 2;
    localparam int PW = WIDTH + 2 * B;
    localparam int PH = HEIGHT + 2 * B;

    localparam logic [15:0] X_LO   = 16'(B);
    localparam logic [15:0] X_HI   = 16'(B + WIDTH);
    localparam logic [15:0] Y_LO   = 16'(B);
    localparam logic [15:0] Y_HI   = 16'(B + HEIGHT);
    localparam logic [15:0] X_LAST = 16'(PW - 1);
    localparam logic [15:0] Y_LAST = 16'(PH - 1);
    localparam logic [31:0] DRAIN_LAST = 32'(FLUSH - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t      state;
    state_t      stateNext;
    logic [15:0] x;
    logic [15:0] y;
    logic [31:0] drainCnt;

    logic        interior;
    logic        lastSlot;
    logic        issue;
    logic        rdreq;

    // Stage 1: the issued slot, waiting one cycle for the FIFO read data.
    logic        s1Valid;
    logic        s1Pad;
    logic [15:0] s1X;
    logic [15:0] s1Y;

    always_comb begin
        stateNext = state;
        issue     = 1'b0;
        rdreq     = 1'b0;
        interior  = (x >= X_LO) && (x < X_HI) && (y >= Y_LO) && (y < Y_HI);
        lastSlot  = (x == X_LAST) && (y == Y_LAST);
        case (state)
            IDLE: begin
                if (iStart) begin
                    stateNext = RUN;
                end
            end
            RUN: begin
                // Pad slots never wait on the FIFO; interior slots stall while it is empty.
                if (!interior) begin
                    issue = 1'b1;
                end else if (!iFifoEmpty) begin
                    issue = 1'b1;
                    rdreq = 1'b1;
                end
                if (issue && lastSlot) begin
                    stateNext = DRAIN;
                end
            end
            DRAIN: begin
                if (drainCnt == DRAIN_LAST) begin
                    stateNext = IDLE;
                end
            end
            default: stateNext = IDLE;
        endcase
    end

    // The pop is combinational, so it must be masked while reset is held.
    assign oFifoRdreq = rdreq && !reset;
    assign oFlush     = (state == DRAIN);
    assign oBusy      = (state != IDLE);

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            x        <= '0;
            y        <= '0;
            drainCnt <= '0;
            s1Valid  <= 1'b0;
            s1Pad    <= 1'b0;
            s1X      <= '0;
            s1Y      <= '0;
            oValid   <= 1'b0;
            oData    <= '0;
            oX       <= '0;
            oY       <= '0;
            oDone    <= 1'b0;
        end else begin
            state <= stateNext;
            oDone <= (state == DRAIN) && (stateNext == IDLE);

            if (state == IDLE) begin
                x <= '0;
                y <= '0;
            end else if (issue) begin
                if (x == X_LAST) begin
                    x <= '0;
                    y <= y + 16'd1;
                end else begin
                    x <= x + 16'd1;
                end
            end

            drainCnt <= (state == DRAIN) ? drainCnt + 32'd1 : '0;

            s1Valid <= issue;
            s1Pad   <= !interior;
            s1X     <= x;
            s1Y     <= y;

            // iFifoQ now holds the pixel popped when this slot was issued.
            oValid <= s1Valid;
            oData  <= (s1Valid && !s1Pad) ? iFifoQ : '0;
            oX     <= s1X;
            oY     <= s1Y;
        end
    end

endmodule

// File: tb/tb_pad_scheduler.sv
// tb/tb_pad_scheduler.sv - scoreboard bench for pad_scheduler with a row-major padded-grid model
module tb_pad_scheduler;

    localparam int W  = 4;
    localparam int H  = 3;
    localparam int K  = 3;
    localparam int FL = 4;
    localparam int B  = (K - 1) / 2;
    localparam int PW = W + 2 * B;
    localparam int PH = H + 2 * B;
    localparam int NPIX = W * H;
    localparam int NSLOT = PW * PH;

    typedef struct {
        logic [23:0] d;
        logic [15:0] x;
        logic [15:0] y;
    } slot_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int nChecks = 0;
    int nFails  = 0;

    task automatic chk(input string name, input longint act, input longint exp);
        nChecks++;
        if (act !== exp) begin
            nFails++;
            $display("FAIL %s: actual 0x%0h required 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------- small-parameter DUT ----------------
    logic        reset;
    logic        iStart;
    logic        fifoEmpty = 1'b1;
    logic [23:0] fifoQ = '0;
    logic        oFifoRdreq;
    logic [23:0] oData;
    logic        oValid;
    logic [15:0] oX;
    logic [15:0] oY;
    logic        oFlush;
    logic        oBusy;
    logic        oDone;

    pad_scheduler #(.WIDTH(W), .HEIGHT(H), .KERNEL(K), .FLUSH(FL), .DW(24)) dut (
        .clk(clk), .reset(reset), .iStart(iStart), .iFifoEmpty(fifoEmpty), .iFifoQ(fifoQ),
        .oFifoRdreq(oFifoRdreq), .oData(oData), .oValid(oValid), .oX(oX), .oY(oY),
        .oFlush(oFlush), .oBusy(oBusy), .oDone(oDone)
    );

    logic [23:0] fifoData[$];
    logic        forcedEmpty = 1'b0;
    logic        rdSeen = 1'b0;
    slot_t       expQ[$];

    int pops, validCnt, firstValidCyc, lastValidCyc, flushCnt, firstFlushCyc, doneCnt, doneCyc;
    int startCyc;

    // FIFO model: the pop seen during a cycle updates the read data just after the next edge.
    always @(posedge clk) begin
        #2;
        if (rdSeen && fifoData.size() > 0) begin
            fifoQ = fifoData.pop_front();
            pops++;
        end
        fifoEmpty = forcedEmpty || (fifoData.size() == 0);
    end

    // Monitor: pops the scoreboard whenever the DUT presents a pixel.
    always @(negedge clk) begin
        slot_t e;
        if (fifoEmpty || reset) chk("rdreq_while_empty_or_reset", 64'(oFifoRdreq), 0);
        rdSeen = oFifoRdreq && !reset;
        if (oValid) begin
            validCnt++;
            lastValidCyc = cyc;
            if (firstValidCyc < 0) firstValidCyc = cyc;
            if (expQ.size() == 0) begin
                chk("unexpected_valid", 64'(oValid), 0);
            end else begin
                e = expQ.pop_front();
                chk("pix_data", 64'(oData), 64'(e.d));
                chk("pix_x", 64'(oX), 64'(e.x));
                chk("pix_y", 64'(oY), 64'(e.y));
            end
        end else begin
            chk("data_zero_when_invalid", 64'(oData), 0);
        end
        if (oFlush) begin
            flushCnt++;
            if (firstFlushCyc < 0) firstFlushCyc = cyc;
        end
        if (oDone) begin
            doneCnt++;
            doneCyc = cyc;
        end
    end

    // Reference: row-major walk of the padded grid, interior slots take the next FIFO pixel.
    task automatic modelFrame(input logic [23:0] pix[$]);
        int k = 0;
        for (int yy = 0; yy < PH; yy++) begin
            for (int xx = 0; xx < PW; xx++) begin
                slot_t s;
                bit inner;
                inner = (xx >= B) && (xx < B + W) && (yy >= B) && (yy < B + H);
                s.d = inner ? pix[k] : 24'd0;
                if (inner) k++;
                s.x = 16'(xx);
                s.y = 16'(yy);
                expQ.push_back(s);
            end
        end
    endtask

    task automatic loadFrame(input bit seq, input bit pushFifo);
        logic [23:0] pix[$];
        for (int i = 0; i < NPIX; i++) begin
            pix.push_back(seq ? 24'(i + 1) : 24'($urandom));
            if (pushFifo) fifoData.push_back(pix[i]);
        end
        modelFrame(pix);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clearStats();
        pops = 0; validCnt = 0; firstValidCyc = -1; lastValidCyc = -1;
        flushCnt = 0; firstFlushCyc = -1; doneCnt = 0; doneCyc = -1;
    endtask

    task automatic startFrame();
        iStart = 1'b1;
        tick();
        iStart = 1'b0;
        startCyc = cyc;
    endtask

    task automatic waitDone(input int target, input int budget, input bit randEmpty);
        int n = 0;
        while (doneCnt < target && n < budget) begin
            if (randEmpty) forcedEmpty = ($urandom_range(0, 3) == 0);
            tick();
            n++;
        end
        chk("done_within_budget", 64'(doneCnt >= target), 1);
        forcedEmpty = 1'b0;
        tick();
    endtask

    task automatic frameChecks(input string tag, input int stalls);
        chk({tag, "_first_valid_rel"}, 64'(firstValidCyc - startCyc), 2);
        chk({tag, "_last_valid_rel"}, 64'(lastValidCyc - startCyc), 64'(NSLOT + 1 + stalls));
        chk({tag, "_valid_count"}, 64'(validCnt), NSLOT);
        chk({tag, "_first_flush_rel"}, 64'(firstFlushCyc - startCyc), 64'(NSLOT + stalls));
        chk({tag, "_flush_count"}, 64'(flushCnt), FL);
        chk({tag, "_done_rel"}, 64'(doneCyc - startCyc), 64'(NSLOT + FL + stalls));
        chk({tag, "_done_count"}, 64'(doneCnt), 1);
        chk({tag, "_pops"}, 64'(pops), NPIX);
        chk({tag, "_scoreboard_drained"}, 64'(expQ.size()), 0);
        chk({tag, "_idle_after"}, 64'(oBusy), 0);
    endtask

    task automatic checkAllZero(input string tag);
        chk({tag, "_oValid"}, 64'(oValid), 0);
        chk({tag, "_oData"}, 64'(oData), 0);
        chk({tag, "_oX"}, 64'(oX), 0);
        chk({tag, "_oY"}, 64'(oY), 0);
        chk({tag, "_oFlush"}, 64'(oFlush), 0);
        chk({tag, "_oBusy"}, 64'(oBusy), 0);
        chk({tag, "_oDone"}, 64'(oDone), 0);
        chk({tag, "_oFifoRdreq"}, 64'(oFifoRdreq), 0);
    endtask

    // ---------------- default-parameter DUT ----------------
    logic        resetD;
    logic        startD;
    logic [23:0] dQ = '0;
    logic        dRdreq;
    logic [23:0] dData;
    logic        dValid;
    logic [15:0] dX;
    logic [15:0] dY;
    logic        dFlush;
    logic        dBusy;
    logic        dDone;

    pad_scheduler dutDefault (
        .clk(clk), .reset(resetD), .iStart(startD), .iFifoEmpty(1'b0), .iFifoQ(dQ),
        .oFifoRdreq(dRdreq), .oData(dData), .oValid(dValid), .oX(dX), .oY(dY),
        .oFlush(dFlush), .oBusy(dBusy), .oDone(dDone)
    );

    logic dRdSeen = 1'b0;
    int dPops = 0, dValidCnt = 0, dNonzero = 0, dFirstValid = -1, dFirstX = -1, dFirstY = -1;
    int dFlushCnt = 0, dDoneCnt = 0, dDoneCyc = -1, dStart = 0;
    bit dflFinished = 1'b0;

    always @(posedge clk) if (dRdSeen) dQ <= dQ + 24'd1;

    always @(negedge clk) begin
        dRdSeen = dRdreq;
        if (dRdreq) dPops++;
        if (dValid) begin
            dValidCnt++;
            if (dFirstValid < 0) dFirstValid = cyc;
            if (dData != 24'd0) begin
                dNonzero++;
                if (dFirstX < 0) begin
                    dFirstX = int'(dX);
                    dFirstY = int'(dY);
                end
            end
        end
        if (dFlush) dFlushCnt++;
        if (dDone) begin
            dDoneCnt++;
            dDoneCyc = cyc;
        end
    end

    initial begin
        int n;
        resetD = 1'b1;
        startD = 1'b0;
        repeat (3) tick();
        resetD = 1'b0;
        startD = 1'b1;
        tick();
        startD = 1'b0;
        dStart = cyc;
        n = 0;
        while (dDoneCnt == 0 && n < 85000) begin
            tick();
            n++;
        end
        tick();
        chk("dfl_done_seen", 64'(dDoneCnt), 1);
        chk("dfl_valid_count", 64'(dValidCnt), 326 * 246);
        chk("dfl_pops", 64'(dPops), 320 * 240);
        chk("dfl_interior_pixels", 64'(dNonzero), 320 * 240);
        chk("dfl_first_interior_x", 64'(dFirstX), 3);
        chk("dfl_first_interior_y", 64'(dFirstY), 3);
        chk("dfl_first_valid_rel", 64'(dFirstValid - dStart), 2);
        chk("dfl_flush_count", 64'(dFlushCnt), 2 * 326);
        chk("dfl_done_rel", 64'(dDoneCyc - dStart), 326 * 246 + 2 * 326);
        chk("dfl_idle_after", 64'(dBusy), 0);
        dflFinished = 1'b1;
    end

    // ---------------- stimulus ----------------
    initial begin
        int n;
        int nA;
        reset = 1'b1;
        iStart = 1'b0;
        clearStats();
        repeat (3) tick();
        checkAllZero("reset");
        reset = 1'b0;
        tick();

        // Full FIFO, sequential data 1..12.
        clearStats();
        loadFrame(1'b1, 1'b1);
        startFrame();
        waitDone(1, 200, 1'b0);
        frameChecks("full", 0);

        // Starvation: FIFO held empty so slot 7 stalls for 3 cycles.
        clearStats();
        forcedEmpty = 1'b1;
        loadFrame(1'b0, 1'b1);
        startFrame();
        while (cyc - startCyc < 10) tick();
        forcedEmpty = 1'b0;
        waitDone(1, 200, 1'b0);
        frameChecks("starve", 3);

        // Empty FIFO for the whole frame: only the top pad row and first left pad emerge.
        clearStats();
        loadFrame(1'b0, 1'b0);
        startFrame();
        repeat (40) tick();
        chk("padstall_valid_count", 64'(validCnt), PW + B);
        chk("padstall_busy", 64'(oBusy), 1);
        chk("padstall_no_done", 64'(doneCnt), 0);
        chk("padstall_no_pops", 64'(pops), 0);
        chk("padstall_remaining", 64'(expQ.size()), NSLOT - PW - B);
        expQ.delete();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        tick();
        chk("padstall_reset_idle", 64'(oBusy), 0);

        // Reset mid-frame at edge 15, then a clean frame.
        clearStats();
        loadFrame(1'b0, 1'b1);
        startFrame();
        while (cyc - startCyc < 14) tick();
        reset = 1'b1;
        tick();
        checkAllZero("midreset");
        reset = 1'b0;
        repeat (2) tick();
        chk("midreset_no_done", 64'(doneCnt), 0);
        expQ.delete();
        fifoData.delete();
        tick();
        clearStats();
        loadFrame(1'b0, 1'b1);
        startFrame();
        waitDone(1, 200, 1'b0);
        frameChecks("postreset", 0);

        // Starts during RUN and DRAIN ignored; start in the oDone cycle chains the next frame.
        clearStats();
        loadFrame(1'b0, 1'b1);
        loadFrame(1'b0, 1'b1);
        startFrame();
        nA = startCyc;
        while (cyc - nA < 10) tick();
        iStart = 1'b1;
        tick();
        iStart = 1'b0;
        while (cyc - nA < 32) tick();
        iStart = 1'b1;
        tick();
        iStart = 1'b0;
        while (cyc - nA < 34) tick();
        chk("b2b_first_done_cycle", 64'(oDone), 1);
        iStart = 1'b1;
        tick();
        iStart = 1'b0;
        waitDone(2, 200, 1'b0);
        chk("b2b_done_count", 64'(doneCnt), 2);
        chk("b2b_second_done_rel", 64'(doneCyc - nA), 35 + NSLOT + FL);
        chk("b2b_last_valid_rel", 64'(lastValidCyc - nA), 35 + NSLOT + 1);
        chk("b2b_valid_count", 64'(validCnt), 2 * NSLOT);
        chk("b2b_flush_count", 64'(flushCnt), 2 * FL);
        chk("b2b_pops", 64'(pops), 2 * NPIX);
        chk("b2b_scoreboard_drained", 64'(expQ.size()), 0);

        // Random data with random FIFO starvation.
        for (int f = 0; f < 4; f++) begin
            clearStats();
            loadFrame(1'b0, 1'b1);
            startFrame();
            waitDone(1, 400, 1'b1);
            chk("rand_first_valid_rel", 64'(firstValidCyc - startCyc), 2);
            chk("rand_valid_count", 64'(validCnt), NSLOT);
            chk("rand_pops", 64'(pops), NPIX);
            chk("rand_flush_count", 64'(flushCnt), FL);
            chk("rand_done_after_last_valid", 64'(doneCyc - lastValidCyc), FL - 1);
            chk("rand_done_count", 64'(doneCnt), 1);
            chk("rand_scoreboard_drained", 64'(expQ.size()), 0);
        end

        n = 0;
        while (!dflFinished && n < 90000) begin
            tick();
            n++;
        end
        chk("dfl_finished", 64'(dflFinished), 1);

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule
